// File: rtl/sysbus_arbiter.sv
// Round-robin arbiter sharing one memory port between two core request ports.
// Optional bus locking is compiled in when the ARB_LOCK_EN macro is defined.
module sysbus_arbiter #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned DATA_W = 64
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              lock0,
    input  logic              lock1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [1:0]        gnt,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        BUSY0 = 3'd1,
        BUSY1 = 3'd2,
        DONE0 = 3'd3,
        DONE1 = 3'd4
    } state_e;

    state_e state_q;
    logic   last_q;
    logic   elig0_c;
    logic   elig1_c;
    logic   pick0_c;
    logic   pick1_c;

`ifdef ARB_LOCK_EN
    logic lock_vld_q;
    logic lock_id_q;
    logic owner_lock_c;
    logic hold_c;

    // A recorded owner that still asserts its lock blocks the other core.
    always_comb begin
        owner_lock_c = lock_id_q ? lock1 : lock0;
        hold_c       = lock_vld_q && owner_lock_c;
    end
`else
    logic unused_lock_c;
    assign unused_lock_c = lock0 ^ lock1;
`endif

    // Eligibility and round-robin tie break; last_q names the core served last.
    always_comb begin
        elig0_c = req0;
        elig1_c = req1;
`ifdef ARB_LOCK_EN
        if (hold_c) begin
            if (lock_id_q) begin
                elig0_c = 1'b0;
            end else begin
                elig1_c = 1'b0;
            end
        end
`endif
        if (elig0_c && elig1_c) begin
            pick0_c = last_q;
            pick1_c = !last_q;
        end else begin
            pick0_c = elig0_c;
            pick1_c = elig1_c;
        end
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_q   <= IDLE;
            last_q    <= 1'b1;
            gnt       <= 2'b00;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            rdata0    <= '0;
            rdata1    <= '0;
`ifdef ARB_LOCK_EN
            lock_vld_q <= 1'b0;
            lock_id_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
`ifdef ARB_LOCK_EN
                    // Release a stale lock first; a fresh locked grant re-records it.
                    if (lock_vld_q && !owner_lock_c) begin
                        lock_vld_q <= 1'b0;
                    end
                    if (pick0_c && lock0) begin
                        lock_vld_q <= 1'b1;
                        lock_id_q  <= 1'b0;
                    end else if (pick1_c && lock1) begin
                        lock_vld_q <= 1'b1;
                        lock_id_q  <= 1'b1;
                    end
`endif
                    if (pick0_c) begin
                        state_q   <= BUSY0;
                        gnt       <= 2'b01;
                        mem_req   <= 1'b1;
                        mem_we    <= we0;
                        mem_addr  <= addr0;
                        mem_wdata <= wdata0;
                    end else if (pick1_c) begin
                        state_q   <= BUSY1;
                        gnt       <= 2'b10;
                        mem_req   <= 1'b1;
                        mem_we    <= we1;
                        mem_addr  <= addr1;
                        mem_wdata <= wdata1;
                    end
                end
                BUSY0: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        ack0    <= 1'b1;
                        last_q  <= 1'b0;
                        state_q <= DONE0;
                        if (!mem_we) begin
                            rdata0 <= mem_rdata;
                        end
                    end
                end
                BUSY1: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        ack1    <= 1'b1;
                        last_q  <= 1'b1;
                        state_q <= DONE1;
                        if (!mem_we) begin
                            rdata1 <= mem_rdata;
                        end
                    end
                end
                DONE0: begin
                    ack0    <= 1'b0;
                    gnt     <= 2'b00;
                    state_q <= IDLE;
                end
                DONE1: begin
                    ack1    <= 1'b0;
                    gnt     <= 2'b00;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sysbus_arbiter.md
# sysbus_arbiter

Two-port arbiter that shares one memory port between core 0 and core 1 of the dual-core RISC. Each core's datapath and control unit issues load/store transactions through its own request port. The arbiter serialises these transactions onto a single memory interface using round-robin priority, and returns read data and a one-cycle acknowledge to the core that owns each transaction.

## Interface
Parameters:
- ADDR_W, 16, width of each memory address.
- DATA_W, 64, width of each data word; matches the Sysbus width.

Ports:
- Clock  in  1  single clock; all state changes on the posedge.
- nReset  in  1  reset, synchronous and active-low.
- req0, req1  in  1  transaction request from core 0 / core 1. The core holds it high until it sees its ack.
- we0, we1  in  1  1 = write, 0 = read. Held stable while req is high.
- addr0, addr1  in  ADDR_W  transaction address. Held stable while req is high.
- wdata0, wdata1  in  DATA_W  write data. Held stable while req is high.
- lock0, lock1  in  1  bus-lock request. Ignored unless ARB_LOCK_EN is defined.
- ack0, ack1  out  1  one-cycle completion pulse to core 0 / core 1.
- rdata0, rdata1  out  DATA_W  registered read data. Valid while ack is high and held until that core's next read completes.
- gnt  out  2  current owner, one-hot: 01 = core 0, 10 = core 1, 00 = none.
- mem_req  out  1  memory transaction active (registered).
- mem_we  out  1  memory write enable (registered).
- mem_addr  out  ADDR_W  memory address (registered).
- mem_wdata  out  DATA_W  memory write data (registered).
- mem_rdata  in  DATA_W  memory read data, valid in the cycle mem_ack is high.
- mem_ack  in  1  memory completion. Sampled only while mem_req is high.

## Operation
State machine states are IDLE, BUSY0, BUSY1 and DONE0, DONE1.

- **Reset values:** state IDLE, last = 1 (so core 0 wins the first tie), gnt = 00. mem_req, mem_we, ack0 and ack1 are 0. mem_addr, mem_wdata, rdata0 and rdata1 are all zeros. The lock owner is cleared.
- **IDLE, grant selection:**
  - Only req0 high → go to BUSY0.
  - Only req1 high → go to BUSY1.
  - Both high → grant the core other than `last`.
  - Neither high → stay in IDLE.
- **IDLE, capture on grant:** at the same edge, capture the winner's we, addr and wdata into the mem_* registers, set mem_req = 1, and set the matching gnt bit.
- **BUSYn, waiting:** the mem_* outputs stay stable and the other core's req is ignored.
- **BUSYn, completion:** on an edge with mem_ack = 1:
  - mem_req goes to 0 and ackn goes to 1.
  - rdatan is loaded from mem_rdata, for reads only.
  - last is set to n and the state moves to DONEn.
- **DONEn:**
  - ackn is high for exactly this cycle and all requests are ignored.
  - The next state is IDLE, with ackn = 0 and gnt = 00.
  - The core must drop reqn in the cycle it sees ack, or it will issue a new transaction.
- **mem_ack outside BUSY:** ignored.
- **Reset while in BUSY:** the transaction is abandoned. mem_req drops at the reset edge, no ack is produced, and the memory must tolerate an unacknowledged request.
- **Simultaneous events:**
  - A request from the non-owner while in BUSY or DONE waits, and wins the next IDLE arbitration because last now points at the other core.
  - req0 and req1 rising in the same cycle resolve purely by `last`.

## Timing
- Grant latency: req sampled in IDLE at edge k → mem_req = 1 visible after edge k.
- Completion latency: mem_ack sampled at edge m → ack and rdata visible after edge m; IDLE follows after edge m+1.
- Minimum transaction: with zero-wait memory (mem_ack = 1 in the first BUSY cycle), req→ack is 2 cycles.
- Minimum issue interval: one transaction every 3 cycles (IDLE→BUSY→DONE).
- Outputs: all outputs are registered; there is no combinational path from any input to any output.

## Configuration
- **Macro ARB_LOCK_EN defined:**
  - A grant made while the winner's lockn = 1 records that core as lock owner.
  - While a lock owner is recorded, IDLE grants only the owner; the other core's req is held off.
  - The owner is cleared in any IDLE cycle where the owner's lock is 0, and normal round-robin arbitration applies in that same cycle.
  - lock is sampled only in IDLE.
- **Macro ARB_LOCK_EN undefined:** lock0 and lock1 are unused, and arbitration is pure round-robin.

## Test plan
- **Reset:** hold nReset = 0 for 2 cycles with req0 = 1 → gnt = 00, mem_req = 0, ack0 = 0 throughout. Release reset → mem_req = 1 one cycle later.
- **Single read:** req0 read of addr 0x0010; mem_ack = 1 in the first BUSY cycle with mem_rdata = 0xDEAD_BEEF_0000_0001 → ack0 high on cycle 2 with rdata0 = that value; rdata1 unchanged.
- **Tie and fairness:** req0 and req1 held high continuously, both writes, with zero-wait memory → mem_addr sequence alternates addr0, addr1, addr0, addr1, starting with core 0 after reset. There is one transaction every 3 cycles.
- **Wait states:** req1 write of 0x1234 to addr 0x0FF0, mem_ack delayed 4 cycles → mem_addr, mem_wdata and mem_we stay stable for all 4 cycles; ack1 is a single pulse; rdata1 is unchanged.
- **Mid-transaction reset:** req0 granted, reset asserted in the second BUSY cycle → no ack0, mem_req = 0 after the reset edge, state IDLE, and last = 1.
- **Lock (ARB_LOCK_EN):**
  - Stimulus: core 0 issues 3 reads with lock0 = 1 while req1 is held high; lock0 then drops.
  - Required response: all 3 grants go to core 0. The next grant goes to core 1 in the first IDLE cycle with lock0 = 0.
